// File: rtl/k_loop_filter.sv
// K-modulus random-walk loop filter for the DPLL.
// Two independent modulo-2^kEff counters (74297 style) turn the phase
// detector's up/down level into single-cycle carry (advance) and borrow
// (retard) pulses for the downstream increment/decrement counter. The
// modulus exponent is selectable at run time and clamped to [3, KW].
module k_loop_filter #(
  parameter int KW     = 8,
  parameter int K_INIT = 4,
  parameter bit SYNC   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          dnUp,
  input  logic [3:0]    kSel,
  output logic          carry,
  output logic          borrow,
  output logic [KW-1:0] upCount,
  output logic [KW-1:0] dnCount,
  output logic [3:0]    kEff
);

  // Reset value of the modulus exponent, already clamped to the legal range.
  localparam int         KINIT_CLAMPED = (K_INIT < 3) ? 3 : ((K_INIT > KW) ? KW : K_INIT);
  localparam logic [3:0] KEFF_RST      = 4'(KINIT_CLAMPED);

  // Clamp a requested exponent to [3, KW]; the smallest modulus is 8.
  function automatic logic [3:0] clamp_k(input logic [3:0] k);
    logic [3:0] res;
    if (k < 4'd3) begin
      res = 4'd3;
    end else if (int'(k) > KW) begin
      res = 4'(KW);
    end else begin
      res = k;
    end
    return res;
  endfunction

  logic          w_d;
  logic [3:0]    w_kReq;
  logic [KW-1:0] w_term;

  logic          r_carry;
  logic          r_borrow;
  logic [KW-1:0] r_up;
  logic [KW-1:0] r_dn;
  logic [3:0]    r_kEff;

  // Direction source: either re-timed through two flops or taken directly.
  generate
    if (SYNC) begin : g_sync
      logic r_sync1;
      logic r_sync2;

      // Two-flop synchronizer for the asynchronous phase-detector level.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= dnUp;
          r_sync2 <= r_sync1;
        end
      end

      assign w_d = r_sync2;
    end else begin : g_nosync
      assign w_d = dnUp;
    end
  endgenerate

  assign w_kReq = clamp_k(kSel);

  // Terminal count M-1. When kEff equals KW the shift falls off the top and
  // the subtraction wraps to all ones, which is exactly 2^KW - 1.
  assign w_term = (KW'(1) << r_kEff) - KW'(1);

  // Modulus update, counting and pulse generation, in priority order:
  // modulus change, counting on the selected side, idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_up     <= '0;
      r_dn     <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_kEff   <= KEFF_RST;
    end else if (w_kReq != r_kEff) begin
      // New modulus: restart both walks from zero, enable is ignored.
      r_kEff   <= w_kReq;
      r_up     <= '0;
      r_dn     <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else if (en) begin
      if (!w_d) begin
        if (r_up == w_term) begin
          r_up    <= '0;
          r_carry <= 1'b1;
        end else begin
          r_up    <= r_up + KW'(1);
          r_carry <= 1'b0;
        end
        r_borrow <= 1'b0;
      end else begin
        if (r_dn == w_term) begin
          r_dn     <= '0;
          r_borrow <= 1'b1;
        end else begin
          r_dn     <= r_dn + KW'(1);
          r_borrow <= 1'b0;
        end
        r_carry <= 1'b0;
      end
    end else begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end
  end

  assign carry   = r_carry;
  assign borrow  = r_borrow;
  assign upCount = r_up;
  assign dnCount = r_dn;
  assign kEff    = r_kEff;

endmodule

// File: doc/k_loop_filter.md
Name: k_loop_filter

Overview:
- K-modulus random-walk loop filter for the DPLL.
- Sits directly upstream of the increment/decrement counter.
- Consumes the phase detector's up/down level and emits one-cycle carry (advance) and borrow (retard) pulses that drive the counter's incIn/decIn.
- Modulus K = 2^k is runtime-selectable, so the lock-time/jitter trade-off can be tuned without re-synthesis.

Parameters:
- KW, 8: counter width; maximum k.
- K_INIT, 4: k value loaded at reset.
- SYNC, 1: 1 = dnUp passes through a 2-flop synchronizer; 0 = dnUp used directly.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; counters hold when low.
- dnUp  input  1  phase-detector output: 0 = count up (carry side), 1 = count down (borrow side).
- kSel  input  4  requested modulus exponent; K = 2^clamp(kSel,3,KW).
- carry  output  1  one-cycle pulse to the downstream incIn.
- borrow  output  1  one-cycle pulse to the downstream decIn.
- upCount  output  KW  up counter value (debug).
- dnCount  output  KW  down-side counter value (debug).
- kEff  output  4  clamped k currently in use.

Behaviour:
- Reset (reset=0, asynchronous):
  - upCount = dnCount = 0.
  - carry = borrow = 0.
  - Synchronizer flops = 0.
  - kEff = clamp(K_INIT,3,KW).
  - Takes effect immediately, independent of clk, including mid-count.
- Direction signal d:
  - SYNC=1: d = dnUp delayed 2 clk cycles.
  - SYNC=0: d = dnUp.
- Modulus: M = 2^kEff. Counters compare against M-1, masked to kEff bits.
- Each rising edge, priority order:
  1. kSel clamp differs from kEff: kEff <= new clamp; both counters <= 0; carry <= 0; borrow <= 0. The count enable is ignored this cycle.
  2. en=1, d=0:
     - upCount==M-1: upCount <= 0, carry <= 1.
     - Otherwise: upCount <= upCount+1, carry <= 0.
     - borrow <= 0; dnCount holds.
  3. en=1, d=1: mirror of item 2 on dnCount/borrow; upCount holds; carry <= 0.
  4. en=0: counters hold; carry <= 0; borrow <= 0.
- Outputs are registered:
  - A pulse is high for exactly the one cycle following the terminal-count edge.
  - Consecutive pulses are possible only at M ≥ 8 spacing, since min M = 8.
  - carry and borrow are never high in the same cycle.
- The up and down counters are independent (74297-style): no cancellation between them, and neither clears the other.
- Wrap-around: counters never exceed M-1. Width arithmetic is KW-bit unsigned; bits at kEff and above are always 0.
- Clamp rule: kSel<3 gives 3; kSel>KW gives KW.
- Latency (SYNC=0, en=1, constant d=0 from reset release): first carry is high in the cycle after the M-th active edge. SYNC=1 adds 2 cycles of latency to direction changes.

Test Plan:
1. SYNC=0, kSel=3, en=1, dnUp=0 after reset release → carry high for 1 cycle after edges 8, 16, 24…; borrow stays 0; upCount cycles 0..7.
2. Same as 1 with dnUp=1 → borrow high every 8 cycles; carry 0; upCount frozen at 0.
3. kSel=3, dnUp toggling every cycle → carry every 16 cycles, borrow every 16 cycles, offset by 1 cycle; the two pulses never coincide.
4. kSel=4, upCount reaches 10, then kSel changes to 5 → next edge: both counters 0, kEff=5, no pulse; next carry 32 active up-cycles later.
5. KW=8: kSel=15 → kEff=8, carry every 256 cycles. kSel=1 → kEff=3.
6. reset dropped asynchronously mid-period with upCount=5 and carry high → all outputs 0 before the next clk edge. After release, counting restarts from 0 with kEff=K_INIT clamp.
7. SYNC=1, dnUp step 0→1 → first dnCount increment occurs 2 cycles later than with SYNC=0.
